draw_rect_multi: RTL and testbench



---
 rtl/draw_rect_multi_if.sv | 23 ++
 rtl/draw_rect_multi.sv | 267 ++++++++++++++++++++++++++
 tb/tb_draw_rect_multi.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_rect_multi_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_if
//  Description : VGA pixel-stream bundle: timing counters, sync and blanking
//                flags plus RGB444 colour. Modport "in" is for a consumer of
//                the stream and modport "out" is for a producer.
//  Fields      : vcount[11:0], vsync, vblnk, hcount[11:0], hsync, hblnk,
//                rgb[11:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_if;
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface
`default_nettype wire

// File: rtl/draw_rect_multi.sv
`default_nettype none
// ============================================================================
//  Module      : draw_rect_multi
//  Description : Overlays up to NUM_RECT solid-colour rectangles on a VGA
//                pixel stream. Rectangle attributes are written into shadow
//                registers through a valid/ready port and copied to the
//                active set on each vblank rising edge, so a frame is never
//                drawn from a half-updated configuration. Two-stage pipeline:
//                stage 1 hit test, stage 2 priority colour select (lowest
//                index wins). Every vga_out field has a latency of 2 cycles.
//  Ports       : clk, rst            pixel clock, sync active-high reset
//                vga_in / vga_out    vga_if stream in / out
//                cfg_valid/cfg_ready config write handshake
//                cfg_idx, cfg_xpos, cfg_ypos, cfg_width, cfg_height,
//                cfg_color, cfg_enable, cfg_blink   rectangle attributes
//                cfg_outline         (only with DRAW_RECT_OUTLINE_EN)
//                frame_cnt           committed-frame counter
//  Options     : DRAW_RECT_OUTLINE_EN - adds a per-rectangle outline mode
//                that draws only the 1-pixel border.
//  Revision    : 1.0  initial release
// ============================================================================
module draw_rect_multi #(
    parameter int          NUM_RECT      = 4,
    parameter int          COORD_W       = 12,
    parameter int          DEFAULT_W     = 8,
    parameter int          DEFAULT_H     = 8,
    parameter logic [11:0] DEFAULT_COLOR = 12'hf_0_f,
    parameter int          BLINK_SHIFT   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    vga_if.in                           vga_in,
    vga_if.out                          vga_out,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [$clog2(NUM_RECT)-1:0] cfg_idx,
    input  logic [COORD_W-1:0]          cfg_xpos,
    input  logic [COORD_W-1:0]          cfg_ypos,
    input  logic [COORD_W-1:0]          cfg_width,
    input  logic [COORD_W-1:0]          cfg_height,
    input  logic [11:0]                 cfg_color,
    input  logic                        cfg_enable,
    input  logic                        cfg_blink,
`ifdef DRAW_RECT_OUTLINE_EN
    input  logic                        cfg_outline,
`endif
    output logic [7:0]                  frame_cnt
);

    localparam int                   c_idx_w = $clog2(NUM_RECT);
    localparam logic [c_idx_w:0]     c_num   = (c_idx_w+1)'(NUM_RECT);
    localparam logic [COORD_W-1:0]   c_def_w = COORD_W'(DEFAULT_W);
    localparam logic [COORD_W-1:0]   c_def_h = COORD_W'(DEFAULT_H);
    localparam logic [COORD_W:0]     c_one   = {{COORD_W{1'b0}}, 1'b1};

    // Shadow (written by config port) and active (used for drawing) sets
    logic [COORD_W-1:0] r_sh_x [NUM_RECT];
    logic [COORD_W-1:0] r_sh_y [NUM_RECT];
    logic [COORD_W-1:0] r_sh_w [NUM_RECT];
    logic [COORD_W-1:0] r_sh_h [NUM_RECT];
    logic [11:0]        r_sh_color [NUM_RECT];
    logic [NUM_RECT-1:0] r_sh_en;
    logic [NUM_RECT-1:0] r_sh_blink;

    logic [COORD_W-1:0] r_ac_x [NUM_RECT];
    logic [COORD_W-1:0] r_ac_y [NUM_RECT];
    logic [COORD_W-1:0] r_ac_w [NUM_RECT];
    logic [COORD_W-1:0] r_ac_h [NUM_RECT];
    logic [11:0]        r_ac_color [NUM_RECT];
    logic [NUM_RECT-1:0] r_ac_en;
    logic [NUM_RECT-1:0] r_ac_blink;

`ifdef DRAW_RECT_OUTLINE_EN
    logic [NUM_RECT-1:0] r_sh_outline;
    logic [NUM_RECT-1:0] r_ac_outline;
`endif

    logic        r_vblnk_prev;
    logic [7:0]  r_frame_cnt;
    logic        w_commit;
    logic        w_wr;

    // Commit on the vblank rising edge; the config port is stalled for that
    // single cycle so a write can never race the shadow-to-active copy.
    assign w_commit  = vga_in.vblnk && !r_vblnk_prev;
    assign cfg_ready = !rst && !w_commit;
    // Out-of-range indices complete the handshake but update nothing.
    assign w_wr      = cfg_valid && cfg_ready && ({1'b0, cfg_idx} < c_num);
    assign frame_cnt = r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RECT; i++) begin
                r_sh_x[i]     <= '0;
                r_sh_y[i]     <= '0;
                r_sh_w[i]     <= c_def_w;
                r_sh_h[i]     <= c_def_h;
                r_sh_color[i] <= DEFAULT_COLOR;
                r_ac_x[i]     <= '0;
                r_ac_y[i]     <= '0;
                r_ac_w[i]     <= c_def_w;
                r_ac_h[i]     <= c_def_h;
                r_ac_color[i] <= DEFAULT_COLOR;
            end
            r_sh_en      <= '0;
            r_sh_blink   <= '0;
            r_ac_en      <= '0;
            r_ac_blink   <= '0;
`ifdef DRAW_RECT_OUTLINE_EN
            r_sh_outline <= '0;
            r_ac_outline <= '0;
`endif
            r_vblnk_prev <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_vblnk_prev <= vga_in.vblnk;
            if (w_commit) begin
                for (int i = 0; i < NUM_RECT; i++) begin
                    r_ac_x[i]     <= r_sh_x[i];
                    r_ac_y[i]     <= r_sh_y[i];
                    r_ac_w[i]     <= r_sh_w[i];
                    r_ac_h[i]     <= r_sh_h[i];
                    r_ac_color[i] <= r_sh_color[i];
                end
                r_ac_en      <= r_sh_en;
                r_ac_blink   <= r_sh_blink;
`ifdef DRAW_RECT_OUTLINE_EN
                r_ac_outline <= r_sh_outline;
`endif
                r_frame_cnt  <= r_frame_cnt + 8'd1;
            end
            if (w_wr) begin
                r_sh_x[cfg_idx]     <= cfg_xpos;
                r_sh_y[cfg_idx]     <= cfg_ypos;
                r_sh_w[cfg_idx]     <= cfg_width;
                r_sh_h[cfg_idx]     <= cfg_height;
                r_sh_color[cfg_idx] <= cfg_color;
                r_sh_en[cfg_idx]    <= cfg_enable;
                r_sh_blink[cfg_idx] <= cfg_blink;
`ifdef DRAW_RECT_OUTLINE_EN
                r_sh_outline[cfg_idx] <= cfg_outline;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: hit test. Bounds are widened by one bit so x+w past the
    // coordinate range clips instead of wrapping to the left edge.
    // ------------------------------------------------------------------
    logic [COORD_W:0]    w_hc;
    logic [COORD_W:0]    w_vc;
    logic [NUM_RECT-1:0] w_hit;

    assign w_hc = (COORD_W+1)'(vga_in.hcount);
    assign w_vc = (COORD_W+1)'(vga_in.vcount);

    for (genvar gi = 0; gi < NUM_RECT; gi++) begin : g_rect
        logic [COORD_W:0] w_x0;
        logic [COORD_W:0] w_x1;
        logic [COORD_W:0] w_y0;
        logic [COORD_W:0] w_y1;
        logic             w_in_x;
        logic             w_in_y;
        logic             w_shown;

        assign w_x0    = {1'b0, r_ac_x[gi]};
        assign w_x1    = w_x0 + {1'b0, r_ac_w[gi]};
        assign w_y0    = {1'b0, r_ac_y[gi]};
        assign w_y1    = w_y0 + {1'b0, r_ac_h[gi]};
        assign w_in_x  = (w_hc >= w_x0) && (w_hc < w_x1);
        assign w_in_y  = (w_vc >= w_y0) && (w_vc < w_y1);
        assign w_shown = r_ac_en[gi] && !(r_ac_blink[gi] && r_frame_cnt[BLINK_SHIFT]);
`ifdef DRAW_RECT_OUTLINE_EN
        logic w_edge;
        assign w_edge = (w_hc == w_x0) || (w_hc == w_x1 - c_one) ||
                        (w_vc == w_y0) || (w_vc == w_y1 - c_one);
        assign w_hit[gi] = w_shown && w_in_x && w_in_y && (!r_ac_outline[gi] || w_edge);
`else
        assign w_hit[gi] = w_shown && w_in_x && w_in_y;
`endif
    end

    logic [NUM_RECT-1:0] r_s1_hit;
    logic [11:0]         r_s1_hcount;
    logic [11:0]         r_s1_vcount;
    logic                r_s1_hsync;
    logic                r_s1_vsync;
    logic                r_s1_hblnk;
    logic                r_s1_vblnk;
    logic [11:0]         r_s1_rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_hit    <= '0;
            r_s1_hcount <= '0;
            r_s1_vcount <= '0;
            r_s1_hsync  <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_rgb    <= '0;
        end else begin
            r_s1_hit    <= w_hit;
            r_s1_hcount <= vga_in.hcount;
            r_s1_vcount <= vga_in.vcount;
            r_s1_hsync  <= vga_in.hsync;
            r_s1_vsync  <= vga_in.vsync;
            r_s1_hblnk  <= vga_in.hblnk;
            r_s1_vblnk  <= vga_in.vblnk;
            r_s1_rgb    <= vga_in.rgb;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: priority select. Scanning from the top index down lets the
    // lowest-index hit overwrite the others.
    // ------------------------------------------------------------------
    logic [11:0] w_rgb;

    always_comb begin
        w_rgb = r_s1_rgb;
        for (int i = NUM_RECT - 1; i >= 0; i--) begin
            if (r_s1_hit[i]) begin
                w_rgb = r_ac_color[i];
            end
        end
    end

    logic [11:0] r_s2_hcount;
    logic [11:0] r_s2_vcount;
    logic        r_s2_hsync;
    logic        r_s2_vsync;
    logic        r_s2_hblnk;
    logic        r_s2_vblnk;
    logic [11:0] r_s2_rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_hcount <= '0;
            r_s2_vcount <= '0;
            r_s2_hsync  <= 1'b0;
            r_s2_vsync  <= 1'b0;
            r_s2_hblnk  <= 1'b0;
            r_s2_vblnk  <= 1'b0;
            r_s2_rgb    <= '0;
        end else begin
            r_s2_hcount <= r_s1_hcount;
            r_s2_vcount <= r_s1_vcount;
            r_s2_hsync  <= r_s1_hsync;
            r_s2_vsync  <= r_s1_vsync;
            r_s2_hblnk  <= r_s1_hblnk;
            r_s2_vblnk  <= r_s1_vblnk;
            r_s2_rgb    <= w_rgb;
        end
    end

    assign vga_out.hcount = r_s2_hcount;
    assign vga_out.vcount = r_s2_vcount;
    assign vga_out.hsync  = r_s2_hsync;
    assign vga_out.vsync  = r_s2_vsync;
    assign vga_out.hblnk  = r_s2_hblnk;
    assign vga_out.vblnk  = r_s2_vblnk;
    assign vga_out.rgb    = r_s2_rgb;

endmodule
`default_nettype wire

// File: tb/tb_draw_rect_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_draw_rect_multi
//  Description : Self-checking bench for draw_rect_multi (BLINK_SHIFT=0).
//                Pixel vectors {hcount, vcount, rgb_in, expected rgb} are
//                held for two clocks and the whole output word is compared.
//                Hand sequences cover latency, commit timing and reset.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_draw_rect_multi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_if u_vin ();
    vga_if u_vout ();

    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_idx;
    logic [11:0] cfg_xpos, cfg_ypos, cfg_width, cfg_height, cfg_color;
    logic        cfg_enable, cfg_blink;
`ifdef DRAW_RECT_OUTLINE_EN
    logic        cfg_outline = 1'b0;
`endif
    logic [7:0]  frame_cnt;

    draw_rect_multi #(
        .NUM_RECT    (4),
        .COORD_W     (12),
        .BLINK_SHIFT (0)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .vga_in     (u_vin),
        .vga_out    (u_vout),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idx    (cfg_idx),
        .cfg_xpos   (cfg_xpos),
        .cfg_ypos   (cfg_ypos),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_color  (cfg_color),
        .cfg_enable (cfg_enable),
        .cfg_blink  (cfg_blink),
`ifdef DRAW_RECT_OUTLINE_EN
        .cfg_outline(cfg_outline),
`endif
        .frame_cnt  (frame_cnt)
    );

    typedef struct {
        logic [11:0] h;
        logic [11:0] v;
        logic [11:0] rgb;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] exp_fc = 8'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] out_word();
        return {8'h00, u_vout.hsync, u_vout.vsync, u_vout.hblnk, u_vout.vblnk,
                u_vout.hcount, u_vout.vcount, u_vout.rgb};
    endfunction

    function automatic logic [47:0] exp_word(input logic [11:0] h, input logic [11:0] v,
                                             input logic [11:0] rgb);
        return {8'h00, h[0], v[0], 1'b0, 1'b0, h, v, rgb};
    endfunction

    task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic [11:0] rgb);
        u_vin.hcount = h;
        u_vin.vcount = v;
        u_vin.rgb    = rgb;
        u_vin.hsync  = h[0];
        u_vin.vsync  = v[0];
        u_vin.hblnk  = 1'b0;
    endtask

    task automatic add(input logic [11:0] h, input logic [11:0] v,
                       input logic [11:0] rgb, input logic [11:0] exp);
        vec_t t;
        t.h = h; t.v = v; t.rgb = rgb; t.exp = exp;
        tbl.push_back(t);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            drive(tbl[i].h, tbl[i].v, tbl[i].rgb);
            tick();
            tick();
            check($sformatf("%s[%0d]", name, i), out_word(),
                  exp_word(tbl[i].h, tbl[i].v, tbl[i].exp));
        end
        tbl.delete();
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [11:0] x, input logic [11:0] y,
                             input logic [11:0] w, input logic [11:0] h,
                             input logic [11:0] color, input logic en, input logic blink);
        int guard;
        cfg_idx = idx; cfg_xpos = x; cfg_ypos = y; cfg_width = w; cfg_height = h;
        cfg_color = color; cfg_enable = en; cfg_blink = blink;
        cfg_valid = 1'b1;
        guard = 0;
        while (!cfg_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("cfg_ready_timeout", {47'b0, cfg_ready}, 48'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic commit();
        u_vin.vblnk = 1'b1;
        tick();
        u_vin.vblnk = 1'b0;
        tick();
        exp_fc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_idx = '0; cfg_xpos = '0; cfg_ypos = '0;
        cfg_width = '0; cfg_height = '0; cfg_color = '0; cfg_enable = 1'b0; cfg_blink = 1'b0;
        u_vin.vblnk = 1'b0;
        drive(12'h345, 12'h123, 12'habc);
        tick();
        tick();

        // Reset state
        check("reset_out", out_word(), 48'h0);
        check("reset_frame_cnt", {40'b0, frame_cnt}, 48'd0);
        check("reset_cfg_ready", {47'b0, cfg_ready}, 48'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {47'b0, cfg_ready}, 48'd1);

        // Latency: a value driven before edge k is visible after edge k+1
        for (int k = 0; k < 6; k++) begin
            drive(12'(500 + k), 12'd7, 12'(12'h100 + k));
            tick();
            if (k == 0)
                check("latency_flush", out_word(), 48'h0);
            else
                check($sformatf("latency[%0d]", k), out_word(),
                      exp_word(12'(500 + k - 1), 12'd7, 12'(12'h100 + k - 1)));
        end

        // Passthrough with no configuration
        commit();
        check("frame_cnt_first", {40'b0, frame_cnt}, {40'b0, exp_fc});
        add(12'd0,   12'd0,   12'h123, 12'h123);
        add(12'd5,   12'd5,   12'h456, 12'h456);
        add(12'd799, 12'd599, 12'hfff, 12'hfff);
        run_table("passthrough");

        // Single rectangle: invisible until the next commit
        cfg_write(2'd0, 12'd100, 12'd50, 12'd8, 12'd4, 12'h0f0, 1'b1, 1'b0);
        add(12'd100, 12'd50, 12'h111, 12'h111);
        run_table("pre_commit");
        commit();
        add(12'd100, 12'd50, 12'h111, 12'h0f0);
        add(12'd107, 12'd53, 12'h222, 12'h0f0);
        add(12'd103, 12'd51, 12'h777, 12'h0f0);
        add(12'd108, 12'd53, 12'h333, 12'h333);
        add(12'd107, 12'd54, 12'h444, 12'h444);
        add(12'd99,  12'd50, 12'h555, 12'h555);
        add(12'd100, 12'd49, 12'h666, 12'h666);
        run_table("single");

        // Priority, with back-to-back writes and last-write-wins on idx1
        cfg_write(2'd0, 12'd10, 12'd10, 12'd20, 12'd20, 12'hf00, 1'b1, 1'b0);
        cfg_write(2'd1, 12'd15, 12'd15, 12'd20, 12'd20, 12'h0f0, 1'b1, 1'b0);
        cfg_write(2'd1, 12'd15, 12'd15, 12'd20, 12'd20, 12'h00f, 1'b1, 1'b0);
        commit();
        add(12'd16,  12'd16, 12'h123, 12'hf00);
        add(12'd32,  12'd32, 12'h123, 12'h00f);
        add(12'd29,  12'd29, 12'h123, 12'hf00);
        add(12'd30,  12'd30, 12'h123, 12'h00f);
        add(12'd34,  12'd34, 12'h123, 12'h00f);
        add(12'd35,  12'd35, 12'h123, 12'h123);
        add(12'd100, 12'd50, 12'h123, 12'h123);
        run_table("priority");

        // Commit safety: write held across the vblank rising edge
        cfg_idx = 2'd2; cfg_xpos = 12'd200; cfg_ypos = 12'd5; cfg_width = 12'd4;
        cfg_height = 12'd4; cfg_color = 12'h0aa; cfg_enable = 1'b1; cfg_blink = 1'b0;
        cfg_valid = 1'b1;
        u_vin.vblnk = 1'b1;
        #1;
        check("ready_low_on_commit", {47'b0, cfg_ready}, 48'd0);
        tick();
        exp_fc++;
        check("ready_high_after_commit", {47'b0, cfg_ready}, 48'd1);
        check("frame_cnt_commit", {40'b0, frame_cnt}, {40'b0, exp_fc});
        tick();
        cfg_valid = 1'b0;
        tick();
        tick();
        tick();
        check("vblnk_held_one_commit", {40'b0, frame_cnt}, {40'b0, exp_fc});
        u_vin.vblnk = 1'b0;
        tick();
        add(12'd200, 12'd5, 12'h123, 12'h123);
        run_table("late_write_hidden");
        commit();
        add(12'd200, 12'd5, 12'h123, 12'h0aa);
        add(12'd203, 12'd8, 12'h123, 12'h0aa);
        add(12'd204, 12'd8, 12'h123, 12'h123);
        run_table("late_write_shown");

        // Blink on frame_cnt[0]
        cfg_write(2'd3, 12'd300, 12'd300, 12'd2, 12'd2, 12'h555, 1'b1, 1'b1);
        commit();
        check("frame_cnt_even", {40'b0, frame_cnt}, 48'd6);
        add(12'd300, 12'd300, 12'h000, 12'h555);
        add(12'd301, 12'd301, 12'h000, 12'h555);
        run_table("blink_even");
        commit();
        add(12'd300, 12'd300, 12'h000, 12'h000);
        run_table("blink_odd");
        commit();
        add(12'd300, 12'd300, 12'h000, 12'h555);
        run_table("blink_even2");

        // Right-edge clipping and zero width
        cfg_write(2'd2, 12'd4090, 12'd0, 12'd20, 12'd4, 12'habc, 1'b1, 1'b0);
        cfg_write(2'd1, 12'd15, 12'd15, 12'd0, 12'd20, 12'h00f, 1'b1, 1'b0);
        commit();
        add(12'd4090, 12'd0,  12'h123, 12'habc);
        add(12'd4095, 12'd3,  12'h123, 12'habc);
        add(12'd4089, 12'd0,  12'h123, 12'h123);
        add(12'd0,    12'd0,  12'h123, 12'h123);
        add(12'd13,   12'd0,  12'h123, 12'h123);
        add(12'd32,   12'd32, 12'h123, 12'h123);
        add(12'd16,   12'd16, 12'h123, 12'hf00);
        run_table("clip");

        // Reset mid-frame
        drive(12'd400, 12'd300, 12'h123);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_out0", out_word(), 48'h0);
        check("midrst_frame_cnt", {40'b0, frame_cnt}, 48'd0);
        check("midrst_ready", {47'b0, cfg_ready}, 48'd0);
        rst = 1'b0;
        exp_fc = 8'd0;
        drive(12'd16, 12'd16, 12'h321);
        tick();
        check("midrst_out1", out_word(), 48'h0);
        tick();
        check("midrst_resume", out_word(), exp_word(12'd16, 12'd16, 12'h321));
        add(12'd4092, 12'd1,   12'h077, 12'h077);
        add(12'd300,  12'd300, 12'h088, 12'h088);
        run_table("after_reset");
        commit();
        check("frame_cnt_after_reset", {40'b0, frame_cnt}, {40'b0, exp_fc});
        add(12'd16, 12'd16, 12'h055, 12'h055);
        run_table("after_reset_commit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
